// File: rtl/ariane_pkg.sv
// Shared core types: the branch-history update record and the sizing
// defaults for the BHT update queue.
package ariane_pkg;

  localparam int unsigned BHT_UPDATE_QUEUE_DEPTH  = 4;
  localparam int unsigned NR_BRANCH_RESOLVE_PORTS = 2;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        taken;
  } bht_update_t;

endpackage

// File: rtl/bht_update_queue.sv
// Multi-port circular buffer between branch resolution and the single BHT
// update port; drains one entry per cycle and counts overflow drops.
module bht_update_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH      = BHT_UPDATE_QUEUE_DEPTH,
  parameter int unsigned NR_PORTS   = NR_BRANCH_RESOLVE_PORTS,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               debug_mode_i,
  input  bht_update_t [NR_PORTS-1:0]         resolve_i,
  output bht_update_t                        bht_update_o,
  output logic        [$clog2(DEPTH):0]      occupancy_o,
  output logic        [DROP_CNT_W-1:0]       drop_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [63:0]          pc_q    [DEPTH];
  logic [63:0]          pc_d    [DEPTH];
  logic [DEPTH-1:0]     taken_q, taken_d;
  ptr_t                 head_q, head_d;
  ptr_t                 tail_q, tail_d;
  cnt_t                 count_q, count_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                 pop;
  cnt_t                 free;
  logic [NR_PORTS-1:0]  elig;
  cnt_t                 n_acc, n_drop, slot;
  ptr_t                 idx;
  logic [DROP_CNT_W:0]  drop_sum;

  // Number of eligible ports below port k: the compacted write offset.
  function automatic cnt_t prefix_count(logic [NR_PORTS-1:0] e, int unsigned k);
    cnt_t c;
    c = '0;
    for (int unsigned j = 0; j < NR_PORTS; j++) begin
      if (j < k && e[j]) c = c + cnt_t'(1);
    end
    return c;
  endfunction

  always_comb begin
    pop  = (count_q != '0) && !debug_mode_i && !flush_i;
    free = cnt_t'(DEPTH) - count_q + cnt_t'(pop);
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      elig[k] = resolve_i[k].valid && !debug_mode_i && !flush_i;
    end

    pc_d    = pc_q;
    taken_d = taken_q;
    n_acc   = '0;
    n_drop  = '0;
    slot    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      if (elig[k]) begin
        slot = prefix_count(elig, k);
        if (slot < free) begin
          idx          = tail_q + slot[PW-1:0];
          pc_d[idx]    = resolve_i[k].pc;
          taken_d[idx] = resolve_i[k].taken;
          n_acc        = n_acc + cnt_t'(1);
        end else begin
          n_drop = n_drop + cnt_t'(1);
        end
      end
    end

    head_d  = head_q + ptr_t'(pop);
    tail_d  = tail_q + n_acc[PW-1:0];
    count_d = count_q - cnt_t'(pop) + n_acc;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    drop_sum = {1'b0, drop_q} + (DROP_CNT_W + 1)'(n_drop);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Payload storage needs no reset: it is only read while count_q != 0.
  always_ff @(posedge clk_i) begin
    pc_q    <= pc_d;
    taken_q <= taken_d;
  end

  assign bht_update_o.valid = pop;
  assign bht_update_o.pc    = pc_q[head_q];
  assign bht_update_o.taken = taken_q[head_q];
  assign occupancy_o        = count_q;
  assign drop_cnt_o         = drop_q;

  a_params: assert property (@(posedge clk_i)
    (NR_PORTS <= DEPTH) && (NR_PORTS >= 1) && (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
  a_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= cnt_t'(DEPTH));

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue with hand-computed expectations.
module tb_bht_update_queue;
  import ariane_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned NR_PORTS = 2;
  localparam int unsigned DW       = 16;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      flush_i;
  logic                      debug_mode_i;
  bht_update_t [NR_PORTS-1:0] resolve_i;
  bht_update_t               bht_update_o;
  logic [$clog2(DEPTH):0]    occupancy_o;
  logic [DW-1:0]             drop_cnt_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bht_update_queue #(.DEPTH(DEPTH), .NR_PORTS(NR_PORTS), .DROP_CNT_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .debug_mode_i (debug_mode_i),
    .resolve_i    (resolve_i),
    .bht_update_o (bht_update_o),
    .occupancy_o  (occupancy_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int unsigned k, input logic v, input logic [63:0] pc, input logic t);
    resolve_i[k].valid = v;
    resolve_i[k].pc    = pc;
    resolve_i[k].taken = t;
  endtask

  task automatic clear_ports();
    for (int unsigned k = 0; k < NR_PORTS; k++) set_port(k, 1'b0, 64'h0, 1'b0);
  endtask

  // Expects a valid update with the given pc/taken and occupancy.
  task automatic expect_out(input string tag, input logic [63:0] pc, input logic t, input int unsigned occ);
    check_eq({tag, ".valid"}, 64'(bht_update_o.valid), 64'd1);
    check_eq({tag, ".pc"},    bht_update_o.pc, pc);
    check_eq({tag, ".taken"}, 64'(bht_update_o.taken), 64'(t));
    check_eq({tag, ".occ"},   64'(occupancy_o), 64'(occ));
  endtask

  task automatic expect_idle(input string tag, input int unsigned occ, input int unsigned drops);
    check_eq({tag, ".valid"}, 64'(bht_update_o.valid), 64'd0);
    check_eq({tag, ".occ"},   64'(occupancy_o), 64'(occ));
    check_eq({tag, ".drop"},  64'(drop_cnt_o), 64'(drops));
  endtask

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    debug_mode_i = 1'b0;
    clear_ports();

    // Reset then idle
    #12;
    expect_idle("reset", 0, 0);
    #10;
    rst_ni = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      expect_idle("idle", 0, 0);
    end

    // Dual push into an empty queue
    set_port(0, 1'b1, 64'h8000_0010, 1'b1);
    set_port(1, 1'b1, 64'h8000_0020, 1'b0);
    #1;
    expect_idle("dual.n", 0, 0);
    tick();
    clear_ports();
    #1;
    expect_out("dual.n1", 64'h8000_0010, 1'b1, 2);
    tick();
    expect_out("dual.n2", 64'h8000_0020, 1'b0, 1);
    tick();
    expect_idle("dual.n3", 0, 0);

    // Overflow with simultaneous pop: A..H = 0x1000 + 0x10*i, taken = i[0]
    set_port(0, 1'b1, 64'h1000, 1'b0); set_port(1, 1'b1, 64'h1010, 1'b1);
    #1; expect_idle("ovf.c1", 0, 0);
    tick();
    set_port(0, 1'b1, 64'h1020, 1'b0); set_port(1, 1'b1, 64'h1030, 1'b1);
    #1; expect_out("ovf.c2", 64'h1000, 1'b0, 2);
    tick();
    set_port(0, 1'b1, 64'h1040, 1'b0); set_port(1, 1'b1, 64'h1050, 1'b1);
    #1; expect_out("ovf.c3", 64'h1010, 1'b1, 3);
    tick();
    set_port(0, 1'b1, 64'h1060, 1'b0); set_port(1, 1'b1, 64'h1070, 1'b1);
    #1; expect_out("ovf.c4", 64'h1020, 1'b0, 4);
    check_eq("ovf.c4.drop", 64'(drop_cnt_o), 64'd0);
    tick();
    clear_ports();
    #1;
    expect_out("ovf.d0", 64'h1030, 1'b1, 4);
    check_eq("ovf.drop", 64'(drop_cnt_o), 64'd1);
    tick(); expect_out("ovf.d1", 64'h1040, 1'b0, 3);
    tick(); expect_out("ovf.d2", 64'h1050, 1'b1, 2);
    tick(); expect_out("ovf.d3", 64'h1060, 1'b0, 1);
    tick(); expect_idle("ovf.end", 0, 1);

    // Flush on empty queue with resolutions presented: silently discarded
    flush_i = 1'b1;
    set_port(0, 1'b1, 64'hdead, 1'b1); set_port(1, 1'b1, 64'hbeef, 1'b1);
    #1; expect_idle("fl0", 0, 1);
    tick();
    flush_i = 1'b0;
    clear_ports();
    #1; expect_idle("fl0.after", 0, 1);

    // Port compaction: only port 1 valid
    set_port(1, 1'b1, 64'h100, 1'b1);
    #1; expect_idle("cmp.n", 0, 1);
    tick();
    clear_ports();
    #1; expect_out("cmp.n1", 64'h100, 1'b1, 1);
    tick(); expect_idle("cmp.n2", 0, 1);

    // Debug hold with 3 entries queued (P2,P3,P4)
    set_port(0, 1'b1, 64'h2000, 1'b0); set_port(1, 1'b1, 64'h2004, 1'b1);
    tick();
    set_port(0, 1'b1, 64'h2008, 1'b0); set_port(1, 1'b1, 64'h200c, 1'b1);
    #1; expect_out("dbg.fill", 64'h2000, 1'b0, 2);
    tick();
    debug_mode_i = 1'b1;
    set_port(0, 1'b1, 64'h9990, 1'b1); set_port(1, 1'b1, 64'h9994, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      #1; expect_idle("dbg.hold", 3, 1);
      tick();
    end
    debug_mode_i = 1'b0;
    clear_ports();
    #1; expect_out("dbg.r0", 64'h2004, 1'b1, 3);
    tick(); expect_out("dbg.r1", 64'h2008, 1'b0, 2);
    tick(); expect_out("dbg.r2", 64'h200c, 1'b1, 1);
    tick(); expect_idle("dbg.end", 0, 1);

    // Flush with 2 queued, then 6 single pushes wrapping the pointers
    set_port(0, 1'b1, 64'h4000, 1'b0); set_port(1, 1'b1, 64'h4004, 1'b1);
    tick();
    flush_i = 1'b1;
    set_port(0, 1'b1, 64'h4008, 1'b1); set_port(1, 1'b0, 64'h0, 1'b0);
    #1; expect_idle("fl2.cyc", 2, 1);
    tick();
    flush_i = 1'b0;
    clear_ports();
    #1; expect_idle("fl2.after", 0, 1);
    for (int unsigned i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 64'h3000 + 64'(i * 4), i[0]);
      #1;
      if (i == 0) check_eq("wrap.first.valid", 64'(bht_update_o.valid), 64'd0);
      else begin
        expect_out("wrap", 64'h3000 + 64'((i - 1) * 4), i[0] ^ 1'b1, 1);
      end
      tick();
    end
    clear_ports();
    #1; expect_out("wrap.last", 64'h3014, 1'b1, 1);
    tick(); expect_idle("wrap.end", 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
